// File: rtl/scsi_port_sequencer_if.sv
// Bus bundle between the requesters (CPU decode / DMA engine) and the
// WD33C93A port sequencer, including the chip-side strobes.
interface scsi_port_sequencer_if;
    logic CPU_REQ;
    logic CPU_RW;
    logic DMA_REQ;
    logic DMA_RW;
    logic CSS_n;
    logic DACK_n;
    logic IOR_n;
    logic IOW_n;
    logic LATCH_EN;
    logic CPU_ACK;
    logic DMA_ACK;
    logic GRANT_DMA;
    logic BUSY;

    modport master (
        output CPU_REQ, CPU_RW, DMA_REQ, DMA_RW,
        input  CSS_n, DACK_n, IOR_n, IOW_n, LATCH_EN,
        input  CPU_ACK, DMA_ACK, GRANT_DMA, BUSY
    );

    modport slave (
        input  CPU_REQ, CPU_RW, DMA_REQ, DMA_RW,
        output CSS_n, DACK_n, IOR_n, IOW_n, LATCH_EN,
        output CPU_ACK, DMA_ACK, GRANT_DMA, BUSY
    );
endinterface

// File: rtl/scsi_port_sequencer.sv
// SCSI port (WD33C93A) access sequencer: round-robin arbitration between
// CPU register cycles and DMA data cycles, with programmable setup /
// strobe / hold timing. All outputs are registered.
module scsi_port_sequencer #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned CNT_W      = 3
) (
    input  logic SCLK,
    input  logic RST,
    scsi_port_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        ACKWAIT
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             owner_dma, owner_dma_n;
    logic             rw, rw_n;
    logic             last_dma, last_dma_n;
    logic             done;
    logic             pick_dma;

    logic css_n_d, dack_n_d, ior_n_d, iow_n_d, latch_d;
    logic cpu_ack_d, dma_ack_d, grant_d, busy_d;
    logic phase;

    // State register: FSM state, phase counter, latched owner/direction.
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            owner_dma <= 1'b0;
            rw        <= 1'b0;
            last_dma  <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            owner_dma <= owner_dma_n;
            rw        <= rw_n;
            last_dma  <= last_dma_n;
        end
    end

    // Next-state logic: arbitration in IDLE, phase counting, completion.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        owner_dma_n = owner_dma;
        rw_n        = rw;
        last_dma_n  = last_dma;
        done        = 1'b0;
        pick_dma    = 1'b0;
        unique case (state)
            IDLE: begin
                // The DMA_ACK cycle is never a grant cycle, so a held
                // DMA_REQ always sees one full IDLE cycle between transfers.
                if (!bus.DMA_ACK && (bus.CPU_REQ || bus.DMA_REQ)) begin
                    pick_dma    = bus.DMA_REQ && (!bus.CPU_REQ || !last_dma);
                    owner_dma_n = pick_dma;
                    rw_n        = pick_dma ? bus.DMA_RW : bus.CPU_RW;
                    last_dma_n  = pick_dma;
                    if (SETUP_CYC != 0) begin
                        state_n = SETUP;
                        cnt_n   = SETUP_LD;
                    end else begin
                        state_n = STROBE;
                        cnt_n   = STROBE_LD;
                    end
                end
            end
            SETUP: begin
                if (cnt == ONE) begin
                    state_n = STROBE;
                    cnt_n   = STROBE_LD;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            STROBE: begin
                if (cnt == ONE) begin
                    if (HOLD_CYC != 0) begin
                        state_n = HOLD;
                        cnt_n   = HOLD_LD;
                    end else begin
                        done = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            HOLD: begin
                if (cnt == ONE) begin
                    done = 1'b1;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            ACKWAIT: begin
                if (!bus.CPU_REQ) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (done) begin
            state_n = owner_dma ? IDLE : ACKWAIT;
            cnt_n   = '0;
        end
    end

    // Output decode from the next state so every output is a register.
    always_comb begin
        phase     = (state_n == SETUP) || (state_n == STROBE) || (state_n == HOLD);
        css_n_d   = !(phase && !owner_dma_n);
        dack_n_d  = !(phase && owner_dma_n);
        ior_n_d   = !((state_n == STROBE) && rw_n);
        iow_n_d   = !((state_n == STROBE) && !rw_n);
        latch_d   = (state_n == STROBE) && rw_n && (cnt_n == ONE);
        cpu_ack_d = (state_n == ACKWAIT);
        dma_ack_d = done && owner_dma;
        grant_d   = phase && owner_dma_n;
        busy_d    = (state_n != IDLE);
    end

    // Output registers.
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            bus.CSS_n     <= 1'b1;
            bus.DACK_n    <= 1'b1;
            bus.IOR_n     <= 1'b1;
            bus.IOW_n     <= 1'b1;
            bus.LATCH_EN  <= 1'b0;
            bus.CPU_ACK   <= 1'b0;
            bus.DMA_ACK   <= 1'b0;
            bus.GRANT_DMA <= 1'b0;
            bus.BUSY      <= 1'b0;
        end else begin
            bus.CSS_n     <= css_n_d;
            bus.DACK_n    <= dack_n_d;
            bus.IOR_n     <= ior_n_d;
            bus.IOW_n     <= iow_n_d;
            bus.LATCH_EN  <= latch_d;
            bus.CPU_ACK   <= cpu_ack_d;
            bus.DMA_ACK   <= dma_ack_d;
            bus.GRANT_DMA <= grant_d;
            bus.BUSY      <= busy_d;
        end
    end

endmodule

// File: tb/tb_scsi_port_sequencer.sv
// Directed testbench for scsi_port_sequencer: default-timing instance (a)
// and a SETUP=0/STROBE=2/HOLD=0 instance (b).
module tb_scsi_port_sequencer;

    logic SCLK = 1'b0;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    always #5 SCLK = ~SCLK;

    scsi_port_sequencer_if bus_a ();
    scsi_port_sequencer_if bus_b ();

    scsi_port_sequencer dut_a (
        .SCLK (SCLK),
        .RST  (RST),
        .bus  (bus_a)
    );

    scsi_port_sequencer #(
        .SETUP_CYC  (0),
        .STROBE_CYC (2),
        .HOLD_CYC   (0),
        .CNT_W      (3)
    ) dut_b (
        .SCLK (SCLK),
        .RST  (RST),
        .bus  (bus_b)
    );

    // Observed outputs: {CSS_n,DACK_n,IOR_n,IOW_n,LATCH_EN,CPU_ACK,DMA_ACK,GRANT_DMA,BUSY}
    logic [8:0] obs_a, obs_b;
    assign obs_a = {bus_a.CSS_n, bus_a.DACK_n, bus_a.IOR_n, bus_a.IOW_n, bus_a.LATCH_EN,
                    bus_a.CPU_ACK, bus_a.DMA_ACK, bus_a.GRANT_DMA, bus_a.BUSY};
    assign obs_b = {bus_b.CSS_n, bus_b.DACK_n, bus_b.IOR_n, bus_b.IOW_n, bus_b.LATCH_EN,
                    bus_b.CPU_ACK, bus_b.DMA_ACK, bus_b.GRANT_DMA, bus_b.BUSY};

    localparam logic [8:0] IDLE_V = 9'b1111_0000_0;

    function automatic logic [8:0] exp_v(input logic css, input logic dck, input logic ior,
                                         input logic iow, input logic lat, input logic cak,
                                         input logic dak, input logic gnt, input logic bsy);
        return {css, dck, ior, iow, lat, cak, dak, gnt, bsy};
    endfunction

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus_a.CPU_REQ = 0; bus_a.CPU_RW = 0; bus_a.DMA_REQ = 0; bus_a.DMA_RW = 0;
        bus_b.CPU_REQ = 0; bus_b.CPU_RW = 0; bus_b.DMA_REQ = 0; bus_b.DMA_RW = 0;
        repeat (3) tick();
        checks++;
        if (obs_a !== IDLE_V) begin
            $display("FAIL reset_a: got %b expected %b", obs_a, IDLE_V); errors++;
        end
        checks++;
        if (obs_b !== IDLE_V) begin
            $display("FAIL reset_b: got %b expected %b", obs_b, IDLE_V); errors++;
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        logic [8:0] e;
        bus_a.CPU_RW  = 1'b1;
        bus_a.CPU_REQ = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c <= 5)
                e = exp_v(0, 1, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, 1, (c == 4), 0, 0, 0, 1);
            else
                e = exp_v(1, 1, 1, 1, 0, 1, 0, 0, 1);
            checks++;
            if (obs_a !== e) begin
                $display("FAIL cpu_read cycle %0d: got %b expected %b", c, obs_a, e); errors++;
            end
        end
        bus_a.CPU_REQ = 1'b0;
        for (int c = 8; c <= 9; c++) begin
            tick();
            checks++;
            if (obs_a !== IDLE_V) begin
                $display("FAIL cpu_read_release cycle %0d: got %b expected %b", c, obs_a, IDLE_V);
                errors++;
            end
        end
    endtask

    task automatic test_dma_write();
        logic [8:0] e;
        bus_b.DMA_RW  = 1'b0;
        bus_b.DMA_REQ = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c <= 2)      e = exp_v(1, 0, 1, 0, 0, 0, 0, 1, 1);
            else if (c == 3) e = exp_v(1, 1, 1, 1, 0, 0, 1, 0, 0);
            else             e = IDLE_V;
            checks++;
            if (obs_b !== e) begin
                $display("FAIL dma_write cycle %0d: got %b expected %b", c, obs_b, e); errors++;
            end
            if (c == 3) bus_b.DMA_REQ = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        int   order [4];
        int   n = 0;
        int   cyc = 0;
        logic prev_css = 1'b1;
        logic prev_dack = 1'b1;
        RST = 1'b1; tick(); RST = 1'b0; tick();
        for (int i = 0; i < 4; i++) order[i] = 2;
        bus_a.CPU_RW = 1'b1; bus_a.DMA_RW = 1'b1;
        bus_a.CPU_REQ = 1'b1; bus_a.DMA_REQ = 1'b1;
        while (n < 4 && cyc < 200) begin
            tick();
            cyc++;
            checks++;
            if (!bus_a.CSS_n && !bus_a.DACK_n) begin
                $display("FAIL rr_select_overlap cycle %0d: got CSS_n=0 DACK_n=0 expected not both 0", cyc);
                errors++;
            end
            checks++;
            if (bus_a.GRANT_DMA !== !bus_a.DACK_n) begin
                $display("FAIL rr_grant_dma cycle %0d: got %b expected %b", cyc, bus_a.GRANT_DMA, !bus_a.DACK_n);
                errors++;
            end
            if (!bus_a.CSS_n && prev_css)   begin order[n] = 0; n++; end
            else if (!bus_a.DACK_n && prev_dack) begin order[n] = 1; n++; end
            prev_css  = bus_a.CSS_n;
            prev_dack = bus_a.DACK_n;
            bus_a.CPU_REQ = bus_a.CPU_ACK ? 1'b0 : 1'b1;
        end
        bus_a.CPU_REQ = 1'b0; bus_a.DMA_REQ = 1'b0;
        cyc = 0;
        while ((bus_a.BUSY || bus_a.DMA_ACK) && cyc < 30) begin tick(); cyc++; end
        checks++;
        if (bus_a.BUSY || bus_a.DMA_ACK) begin
            $display("FAIL rr_drain: got busy=%b expected 0 within 30 cycles", bus_a.BUSY); errors++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] !== (i % 2)) begin
                $display("FAIL rr_order grant %0d: got %0d expected %0d", i, order[i], i % 2); errors++;
            end
        end
        tick();
    endtask

    task automatic test_cpu_drop();
        int strobe_n = 0, ior_n = 0, css_n = 0, ack_n = 0;
        bus_a.CPU_RW  = 1'b0;
        bus_a.CPU_REQ = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (!bus_a.IOW_n) strobe_n++;
            if (!bus_a.IOR_n) ior_n++;
            if (!bus_a.CSS_n) css_n++;
            if (bus_a.CPU_ACK) ack_n++;
            if (c == 2) bus_a.CPU_REQ = 1'b0;
        end
        checks++;
        if (strobe_n !== 3) begin
            $display("FAIL cpu_drop_strobe: got %0d cycles expected 3", strobe_n); errors++;
        end
        checks++;
        if (css_n !== 5) begin
            $display("FAIL cpu_drop_select: got %0d cycles expected 5", css_n); errors++;
        end
        checks++;
        if (ack_n !== 1) begin
            $display("FAIL cpu_drop_ack: got %0d cycles expected 1", ack_n); errors++;
        end
        checks++;
        if (ior_n !== 0) begin
            $display("FAIL cpu_drop_ior: got %0d cycles expected 0", ior_n); errors++;
        end
        checks++;
        if (obs_a !== IDLE_V) begin
            $display("FAIL cpu_drop_idle: got %b expected %b", obs_a, IDLE_V); errors++;
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] e;
        int acks = 0;
        bus_a.DMA_RW  = 1'b1;
        bus_a.DMA_REQ = 1'b1;
        tick(); tick();
        e = exp_v(1, 0, 0, 1, 0, 0, 0, 1, 1);
        checks++;
        if (obs_a !== e) begin
            $display("FAIL rst_mid_strobe: got %b expected %b", obs_a, e); errors++;
        end
        #3;
        RST = 1'b1;
        bus_a.DMA_REQ = 1'b0;
        #1;
        checks++;
        if (obs_a !== IDLE_V) begin
            $display("FAIL rst_mid_async: got %b expected %b", obs_a, IDLE_V); errors++;
        end
        tick();
        RST = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus_a.DMA_ACK || bus_a.BUSY) acks++;
        end
        checks++;
        if (acks !== 0) begin
            $display("FAIL rst_mid_no_ack: got %0d active cycles expected 0", acks); errors++;
        end
        bus_a.DMA_REQ = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c <= 5)
                e = exp_v(1, 0, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, 1, (c == 4), 0, 0, 1, 1);
            else if (c == 6)
                e = exp_v(1, 1, 1, 1, 0, 0, 1, 0, 0);
            else
                e = IDLE_V;
            checks++;
            if (obs_a !== e) begin
                $display("FAIL rst_mid_fresh cycle %0d: got %b expected %b", c, obs_a, e); errors++;
            end
            if (c == 6) bus_a.DMA_REQ = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        int k;
        bus_a.DMA_RW  = 1'b0;
        bus_a.DMA_REQ = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            k = ((c - 1) % 7) + 1;
            if (k <= 5)
                e = exp_v(1, 0, 1, (k >= 2 && k <= 4) ? 1'b0 : 1'b1, 0, 0, 0, 1, 1);
            else if (k == 6)
                e = exp_v(1, 1, 1, 1, 0, 0, 1, 0, 0);
            else
                e = IDLE_V;
            checks++;
            if (obs_a !== e) begin
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c, obs_a, e); errors++;
            end
            if (c == 13) bus_a.DMA_REQ = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_round_robin();
        test_cpu_drop();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/scsi_port_sequencer.md
Name: scsi_port_sequencer

Overview:
Sequences every access to the SCSI port (WD33C93A) on the SDMAC replacement. Two requesters share the port:
- CPU register accesses, already qualified by the address decoder.
- DMA data-register transfers requested by the DMA engine.

The block arbitrates between them and generates chip-select, read/write strobes with programmable setup/strobe/hold timing, a read-data latch enable and completion acknowledges.

Parameters:
SETUP_CYC, 1, cycles chip-select (CSS_n/DACK_n) is asserted before the strobe; 0 skips SETUP.
STROBE_CYC, 3, cycles IOR_n/IOW_n is asserted; minimum 1.
HOLD_CYC, 1, cycles chip-select is held after the strobe negates; 0 skips HOLD.
CNT_W, 3, width of the phase counter; must hold max(SETUP_CYC, STROBE_CYC, HOLD_CYC).

Ports:
SCLK  input  1  system clock; all state changes on the rising edge.
RST  input  1  asynchronous active-high reset.
CPU_REQ  input  1  synchronous CPU access request (decoded port-0 select qualified by address strobe); level, held until acknowledged.
CPU_RW  input  1  CPU direction; 1 = read, 0 = write; sampled at grant.
DMA_REQ  input  1  DMA engine transfer request; level.
DMA_RW  input  1  DMA direction; 1 = read from SCSI chip; sampled at grant.
CSS_n  output  1  SCSI chip select for CPU register cycles, active low.
DACK_n  output  1  SCSI DMA acknowledge for data cycles, active low.
IOR_n  output  1  read strobe, active low.
IOW_n  output  1  write strobe, active low.
LATCH_EN  output  1  one-cycle pulse to capture read data.
CPU_ACK  output  1  CPU cycle complete (drives DSACK logic); level.
DMA_ACK  output  1  one-cycle pulse: DMA transfer complete.
GRANT_DMA  output  1  high while the current cycle belongs to DMA.
BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Every output is registered.
- Reset values: CSS_n=1, DACK_n=1, IOR_n=1, IOW_n=1, LATCH_EN=0, CPU_ACK=0, DMA_ACK=0, GRANT_DMA=0, BUSY=0, state=IDLE, last_owner=DMA.
- States: IDLE, SETUP, STROBE, HOLD, ACKWAIT.
- IDLE arbitration, at the edge where a request is sampled:
  - Only one request asserted: grant it.
  - Both asserted: grant the owner that is not last_owner (round-robin); after reset CPU wins the first tie.
  - On grant: latch owner and direction, update last_owner, go to SETUP (or STROBE if SETUP_CYC=0).
- Select signals: the owner's select (CSS_n for CPU, DACK_n for DMA) is low throughout SETUP, STROBE and HOLD.
- Strobes: IOR_n (read) or IOW_n (write) is low only during STROBE.
- Phase lengths: SETUP lasts SETUP_CYC cycles, STROBE lasts STROBE_CYC cycles, HOLD lasts HOLD_CYC cycles. A down-counter is loaded on each phase entry.
- LATCH_EN pulses high for the last STROBE cycle of read cycles only.
- Leaving HOLD (or STROBE if HOLD_CYC=0):
  - CPU owner: go to ACKWAIT with CPU_ACK=1.
  - DMA owner: DMA_ACK=1 for exactly one cycle, go to IDLE.
- ACKWAIT: CPU_ACK stays high until CPU_REQ is sampled low, then CPU_ACK=0 and go to IDLE. No new grant is issued in the cycle CPU_ACK falls.
- Default timing (1,3,1), request sampled at edge 0:
  - select low for cycles 1–5;
  - strobe low for cycles 2–4;
  - LATCH_EN in cycle 4;
  - CPU_ACK from cycle 6, or DMA_ACK in cycle 6 only.
- Request withdrawn mid-cycle (CPU_REQ or DMA_REQ falls before completion): the chip cycle is never truncated; it runs to the end of HOLD.
  - CPU then passes through ACKWAIT for one cycle with CPU_ACK=1 and returns to IDLE.
  - DMA still pulses DMA_ACK.
- Direction inputs are ignored after grant.
- A DMA_REQ held continuously yields back-to-back transfers separated by at least one IDLE cycle. A pending CPU_REQ wins the next tie.
- RST asserted mid-cycle: all outputs return to reset values immediately (asynchronous) and the state returns to IDLE. The aborted cycle is not acknowledged.
- Invariants: CSS_n and DACK_n are never low simultaneously; IOR_n and IOW_n are never low simultaneously.

Test Plan:
- CPU read, defaults: CPU_REQ=1, CPU_RW=1 at edge 0 → CSS_n low cycles 1–5; IOR_n low cycles 2–4; LATCH_EN=1 in cycle 4 only; CPU_ACK=1 from cycle 6 until CPU_REQ dropped, then 0 next cycle; BUSY=0 after.
- DMA write, SETUP_CYC=0, HOLD_CYC=0, STROBE_CYC=2: DMA_REQ=1, DMA_RW=0 → DACK_n and IOW_n low for 2 cycles; DMA_ACK single pulse; CSS_n stays 1; no LATCH_EN.
- Simultaneous CPU_REQ and DMA_REQ after reset, both held → grant order CPU, DMA, CPU, DMA; GRANT_DMA toggles accordingly; select signals are never both low.
- CPU_REQ dropped during STROBE → strobe still spans 3 cycles; CPU_ACK high exactly 1 cycle; return to IDLE.
- RST pulsed during STROBE of a DMA read → IOR_n and DACK_n return to 1 asynchronously; no DMA_ACK; next DMA_REQ starts a fresh full-length cycle.
- Continuous DMA_REQ with no CPU activity → consecutive transfers with one IDLE cycle between DMA_ACK and the next DACK_n assertion.
